// File: rtl/score_bcd_converter_if.sv
// score_bcd_converter_if: bus between a binary counter keeper and its BCD display converter
// master: drives bin_in, observes bcd_out/blank/overflow/bcd_valid/busy
// slave:  the converter
interface score_bcd_converter_if #(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 4
);
  logic [BIN_W-1:0]    bin_in;
  logic [4*DIGITS-1:0] bcd_out;
  logic [DIGITS-1:0]   blank;
  logic                overflow;
  logic                bcd_valid;
  logic                busy;
  modport master (output bin_in, input bcd_out, blank, overflow, bcd_valid, busy);
  modport slave  (input bin_in, output bcd_out, blank, overflow, bcd_valid, busy);
endinterface

// File: rtl/score_bcd_converter.sv
// score_bcd_converter: iterative double-dabble binary-to-BCD converter, retriggered on input change
// Clk, Reset (sync, active-high); bus.bin_in in; bus.bcd_out/blank/overflow/bcd_valid/busy out
module score_bcd_converter #(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 4,
  parameter int CONV_W = 14
) (
  input logic                  Clk,
  input logic                  Reset,
  score_bcd_converter_if.slave bus
);
  localparam int cnt_w = CONV_W > 1 ? $clog2(CONV_W) : 1;
  localparam logic [BIN_W-1:0] max_val = BIN_W'(10**DIGITS - 1);
  localparam logic [DIGITS-1:0] blank_rst = {{(DIGITS-1){1'b1}}, 1'b0};
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t              state;
  logic [BIN_W-1:0]    last;
  logic [CONV_W-1:0]   bin_sr;
  logic [4*DIGITS-1:0] bcd_sr, adj;
  logic [cnt_w-1:0]    cnt;
  logic                ovf_pending, sat;
  logic [4*DIGITS-1:0] bcd_q;
  logic [DIGITS-1:0]   blank_q, blank_nxt;
  logic                ovf_q, valid_q, busy_q;
  assign sat = bus.bin_in > max_val;
  always_comb begin
    adj = bcd_sr;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i+:4] = bcd_sr[4*i+:4] >= 4'd5 ? bcd_sr[4*i+:4] + 4'd3 : bcd_sr[4*i+:4];
  end
  // leading-zero run scanned from the most significant digit down; digit 0 is never blanked
  always_comb begin
    blank_nxt = '0;
    for (int i = DIGITS - 1, z = 1; i > 0; i--) begin
      z = z & int'(bcd_sr[4*i+:4] == 4'd0);
      blank_nxt[i] = z[0];
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      last        <= '0;
      bin_sr      <= '0;
      bcd_sr      <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
      bcd_q       <= '0;
      blank_q     <= blank_rst;
      ovf_q       <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: if (bus.bin_in != last) begin
          last        <= bus.bin_in;
          bin_sr      <= CONV_W'(sat ? max_val : bus.bin_in);
          ovf_pending <= sat;
          bcd_sr      <= '0;
          cnt         <= '0;
          busy_q      <= 1'b1;
          state       <= SHIFT;
        end
        SHIFT: begin
          {bcd_sr, bin_sr} <= {adj, bin_sr} << 1;
          cnt <= cnt + 1'b1;
          if (cnt == cnt_w'(CONV_W - 1)) begin
            busy_q <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          bcd_q   <= bcd_sr;
          blank_q <= blank_nxt;
          ovf_q   <= ovf_pending;
          valid_q <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.bcd_out   = bcd_q;
  assign bus.blank     = blank_q;
  assign bus.overflow  = ovf_q;
  assign bus.bcd_valid = valid_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_score_bcd_converter.sv
// tb_score_bcd_converter: directed table, corner sequences and random trials for score_bcd_converter
module tb_score_bcd_converter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int fails = 0;
  score_bcd_converter_if #(.BIN_W(32), .DIGITS(4)) bus ();
  score_bcd_converter #(.BIN_W(32), .DIGITS(4), .CONV_W(14)) dut (
    .Clk(clk), .Reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] bin;
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic        ovf;
  } vec_t;
  vec_t tbl[10];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    while (bus.bcd_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
  endtask
  task automatic chk_out(input string nm, input logic [15:0] bcd, input logic [3:0] bl, input logic ovf);
    chk({nm, ".bcd"}, 32'(bus.bcd_out), 32'(bcd));
    chk({nm, ".blank"}, 32'(bus.blank), 32'(bl));
    chk({nm, ".ovf"}, 32'(bus.overflow), 32'(ovf));
  endtask
  task automatic run_vec(input string nm, input logic [31:0] b, input logic [15:0] bcd,
                         input logic [3:0] bl, input logic ovf);
    int n;
    bus.bin_in = b;
    step();
    chk({nm, ".busy"}, 32'(bus.busy), 32'd1);
    wait_valid(n);
    chk({nm, ".latency"}, n, 32'd15);
    chk_out(nm, bcd, bl, ovf);
    step();
    chk({nm, ".pulse"}, 32'(bus.bcd_valid), 32'd0);
  endtask
  function automatic void model(input logic [31:0] b, output logic [15:0] bcd,
                                output logic [3:0] bl, output logic ovf);
    int v, z;
    ovf = b > 32'd9999;
    v = ovf ? 9999 : int'(b);
    bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    bl = 4'b0;
    z = 1;
    for (int i = 3; i > 0; i--) begin
      z = z & int'(bcd[4*i+:4] == 4'd0);
      bl[i] = z[0];
    end
  endfunction
  initial begin
    int n, saw_valid, saw_busy;
    logic [31:0] b, prev;
    logic [15:0] eb;
    logic [3:0] ebl;
    logic eo;
    tbl = '{
      '{32'd1234,       16'h1234, 4'b0000, 1'b0},
      '{32'd7,          16'h0007, 4'b1110, 1'b0},
      '{32'd9999,       16'h9999, 4'b0000, 1'b0},
      '{32'd10000,      16'h9999, 4'b0000, 1'b1},
      '{32'hFFFF_FFFF,  16'h9999, 4'b0000, 1'b1},
      '{32'd0,          16'h0000, 4'b1110, 1'b0},
      '{32'd50,         16'h0050, 4'b1100, 1'b0},
      '{32'd100,        16'h0100, 4'b1000, 1'b0},
      '{32'd9000,       16'h9000, 4'b0000, 1'b0},
      '{32'd1,          16'h0001, 4'b1110, 1'b0}
    };
    bus.bin_in = '0;
    step();
    step();
    reset = 1'b0;
    chk_out("reset", 16'h0000, 4'b1110, 1'b0);
    chk("reset.valid", 32'(bus.bcd_valid), 32'd0);
    chk("reset.busy", 32'(bus.busy), 32'd0);
    saw_valid = 0;
    saw_busy = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      saw_valid |= int'(bus.bcd_valid);
      saw_busy |= int'(bus.busy);
    end
    chk("idle0.valid", saw_valid, 0);
    chk("idle0.busy", saw_busy, 0);
    chk_out("idle0", 16'h0000, 4'b1110, 1'b0);
    for (int i = 0; i < 10; i++)
      run_vec($sformatf("tbl%0d", i), tbl[i].bin, tbl[i].bcd, tbl[i].blank, tbl[i].ovf);
    bus.bin_in = 32'd42;
    step();
    for (int i = 0; i < 5; i++) step();
    bus.bin_in = 32'd99;
    n = 5;
    while (bus.bcd_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("chg.latency1", n, 15);
    chk_out("chg.first", 16'h0042, 4'b1100, 1'b0);
    step();
    wait_valid(n);
    chk("chg.latency2", n + 1, 16);
    chk_out("chg.second", 16'h0099, 4'b1100, 1'b0);
    step();
    bus.bin_in = 32'd5678;
    step();
    for (int i = 0; i < 8; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_out("rst_mid", 16'h0000, 4'b1110, 1'b0);
    chk("rst_mid.busy", 32'(bus.busy), 32'd0);
    chk("rst_mid.valid", 32'(bus.bcd_valid), 32'd0);
    wait_valid(n);
    chk("rst_mid.latency", n, 16);
    chk_out("rst_mid.after", 16'h5678, 4'b0000, 1'b0);
    step();
    prev = 32'd5678;
    for (int t = 0; t < 1000; t++) begin
      do b = (t % 4 == 0) ? $urandom : 32'($urandom_range(0, 12000)); while (b == prev);
      prev = b;
      model(b, eb, ebl, eo);
      run_vec($sformatf("rnd%0d", t), b, eb, ebl, eo);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
